tile_map_renderer: RTL and testbench
====================================

Name: tile_map_renderer

Overview:
- Parametrised successor to the team's tile-map row generator.
- Holds a COLS x ROWS grid of TILE_BITS-wide tile codes and accepts tile-write and clear commands over a valid/ready handshake.
- Serves pipelined display-line reads: each requested line is expanded horizontally (TILE_PX copies per tile) and padded.
- Sits between the command decoder (UART/SPI front end) and the VGA line driver.

Parameters:
- COLS, 56, tiles per row.
- ROWS, 32, tile rows.
- TILE_BITS, 6, bits per tile code.
- TILE_PX, 15, horizontal/vertical pixel repeat per tile at scale 1.
- PAD_BITS, 24, zero bits on each side of line_data.
- LINE_W, COLS*TILE_BITS*TILE_PX+2*PAD_BITS, line_data width (5088 at defaults).

Ports:
- clk50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- scale  in  2  0=x1, 1=x2, 3=x4; 2 is treated as 0; sampled per command/request.
- cmd  in  18+TILE_BITS  {x[7:0], y[7:0], op[1:0], data[TILE_BITS-1:0]}, MSB first.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on valid&&ready.
- err_oob  out  1  one-cycle pulse: accepted write had x>=COLS or y>=ROWS.
- line_req  in  1  line request strobe, one per cycle allowed.
- line_num  in  9  display line number.
- line_valid  out  1  one-cycle pulse, line_data valid.
- line_data  out  LINE_W  expanded line, tile 0 in the most significant slot after the pad.

Behaviour:
- Reset (asynchronous): state IDLE; cmd_ready=1; err_oob=0; line_valid=0; line_data=0; pipeline stages invalid. Map contents are not reset; clear via op 2.
- Ops:
  - op 0 writes data to tile (x,y).
  - op 1 writes data to tiles x..x+S-1 of row y, where S=1/2/4 from scale; tiles past COLS-1 are truncated silently.
  - op 2 fills the whole map with data.
  - op 3 is a NOP unless TILE_READBACK_EN is defined.
- Op 0/1 with x>=COLS or y>=ROWS: accepted, no write, err_oob pulses the cycle after acceptance.
- Writes complete in the accept cycle; the map is updated at the following edge.
- FSM:
  - IDLE: cmd_ready=1. Op 2 accepted -> CLEAR with row counter=0.
  - CLEAR: cmd_ready=0; writes one full row per cycle; after row ROWS-1 -> IDLE.
  - A clear takes exactly ROWS cycles; cmd_ready returns high on cycle ROWS+1 after acceptance.
- Line pipeline, 2-cycle latency, fully pipelined:
  - Stage 1 computes tile_row = line_num / (TILE_PX*S) and registers the row read.
  - Stage 2 registers the expansion; line_valid follows line_req by exactly 2 cycles.
  - tile_row >= ROWS: line_data=0 with line_valid still asserted.
- Read and write to the same row in the same cycle: the read returns pre-write data.
- Reads during CLEAR return the current mixed state; no stall.
- line_data holds its last value while line_valid=0.
- Division uses integer floor; the divisor is at most 60 and the quotient is 9 bits wide.
- reset_n asserted mid-CLEAR: FSM returns to IDLE and the partially cleared map is kept.

Optional Feature:
- Macro: TILE_READBACK_EN.
- Defined:
  - Adds ports rd_valid (out 1) and rd_data (out TILE_BITS).
  - Op 3 at an in-range (x,y) returns that tile on rd_data with rd_valid pulsing 1 cycle after acceptance.
  - Out of range: rd_data=0, rd_valid pulses, err_oob pulses.
  - Both outputs reset to 0.
- Undefined: ports absent; op 3 is accepted and ignored, with no err_oob.

Test Plan:
- Reset, then op 2 data=0: cmd_ready low for exactly 32 cycles. Request line 0 -> line_data all zero after 2 cycles.
- op 0 x=0,y=0,data=6'h3F, then line_req line_num=14: bits [5063:4974] all 1, rest 0. line_num=15 -> all zero.
- scale=3, op 1 x=54,y=1,data=6'h15: tiles 54,55 become 6'h15, no wrap to row 2, no err_oob. Line 60 (tile_row 1 at scale x4) shows them.
- op 0 x=56,y=0: cmd accepted, err_oob pulses once, map unchanged.
- Back-to-back line_req on lines 0,15,30,479 over 4 cycles: 4 line_valid pulses on consecutive cycles 2 later, in order. Line 479 at scale x1 gives tile_row 31.
- TILE_READBACK_EN: write x=3,y=7,data=6'h2A, then op 3 x=3,y=7 -> rd_valid 1 cycle after accept with rd_data=6'h2A.

Source files
------------

// File: rtl/tile_map_renderer_if.sv
// tile_map_renderer_if: command and display-line bus between the command
// decoder (master) and the tile map renderer (slave).
//   scale      : 2-bit scale select, sampled per command / line request
//   cmd        : {x[7:0], y[7:0], op[1:0], data[TILE_BITS-1:0]}
//   cmd_valid  : command present;  cmd_ready : command accepted on valid&&ready
//   err_oob    : one-cycle pulse for an out-of-range command
//   line_req   : line request strobe;  line_num : display line number
//   line_valid : one-cycle pulse;      line_data : expanded, padded line
//   rd_valid / rd_data : tile readback, present only with TILE_READBACK_EN
interface tile_map_renderer_if #(
   parameter int TILE_BITS = 6,
   parameter int LINE_W    = 5088
);
   logic [1:0]            scale;
   logic [17+TILE_BITS:0] cmd;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  err_oob;
   logic                  line_req;
   logic [8:0]            line_num;
   logic                  line_valid;
   logic [LINE_W-1:0]     line_data;
`ifdef TILE_READBACK_EN
   logic                  rd_valid;
   logic [TILE_BITS-1:0]  rd_data;

   modport master (output scale, cmd, cmd_valid, line_req, line_num,
                   input  cmd_ready, err_oob, line_valid, line_data, rd_valid, rd_data);
   modport slave  (input  scale, cmd, cmd_valid, line_req, line_num,
                   output cmd_ready, err_oob, line_valid, line_data, rd_valid, rd_data);
`else
   modport master (output scale, cmd, cmd_valid, line_req, line_num,
                   input  cmd_ready, err_oob, line_valid, line_data);
   modport slave  (input  scale, cmd, cmd_valid, line_req, line_num,
                   output cmd_ready, err_oob, line_valid, line_data);
`endif
endinterface

// File: rtl/tile_map_renderer.sv
// tile_map_renderer: COLS x ROWS map of TILE_BITS-wide tile codes written by
// tile/span/clear commands, read back as horizontally expanded display lines
// through a 2-stage pipeline.
// Ports:
//   clk50   : system clock
//   reset_n : asynchronous active-low reset (map contents are not reset)
//   bus     : tile_map_renderer_if.slave (command + line interface)
// Optional feature macro: TILE_READBACK_EN (op 3 returns a tile on rd_data).
//
// state | meaning
// IDLE  | accepting commands, cmd_ready high
// CLEAR | filling one map row per cycle with the clear value
module tile_map_renderer #(
   parameter int COLS      = 56,
   parameter int ROWS      = 32,
   parameter int TILE_BITS = 6,
   parameter int TILE_PX   = 15,
   parameter int PAD_BITS  = 24,
   parameter int LINE_W    = COLS*TILE_BITS*TILE_PX + 2*PAD_BITS
) (
   input logic                clk50,
   input logic                reset_n,
   tile_map_renderer_if.slave bus
);
   localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int ROW_BITS = COLS*TILE_BITS;
   localparam int CHUNK    = TILE_PX*TILE_BITS;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t               state_q, state_d;
   logic [RW-1:0]        clr_row_q, clr_row_d;
   logic [TILE_BITS-1:0] clr_data_q, clr_data_d;
   logic                 err_q, err_d;
   logic                 cmd_ready_c;

   // Map rows hold tile 0 in the most significant slot.
   logic [ROW_BITS-1:0]  map_q [ROWS];

   logic                 row_we;
   logic [RW-1:0]        row_idx;
   logic [COLS-1:0]      row_mask;
   logic [TILE_BITS-1:0] row_tile;

   logic [7:0]           cmd_x, cmd_y;
   logic [1:0]           cmd_op;
   logic [TILE_BITS-1:0] cmd_data;
   logic                 cmd_oob;
   int                   cmd_span;

   logic [8:0]           px_div, tile_row;
   logic                 s1_valid_q;
   logic [ROW_BITS-1:0]  s1_row_q;
   logic                 line_valid_q;
   logic [LINE_W-1:0]    line_data_q, line_exp;

`ifdef TILE_READBACK_EN
   logic                 rd_valid_q, rd_valid_d;
   logic [TILE_BITS-1:0] rd_data_q, rd_data_d;
`endif

   // Scale code 2 is unused and behaves like x1.
   function automatic int span_of(input logic [1:0] s);
      case (s)
         2'd1:    return 2;
         2'd3:    return 4;
         default: return 1;
      endcase
   endfunction

   assign cmd_x    = bus.cmd[TILE_BITS+17 -: 8];
   assign cmd_y    = bus.cmd[TILE_BITS+9 -: 8];
   assign cmd_op   = bus.cmd[TILE_BITS+1 -: 2];
   assign cmd_data = bus.cmd[TILE_BITS-1:0];
   assign cmd_oob  = (int'(cmd_x) >= COLS) || (int'(cmd_y) >= ROWS);
   assign cmd_span = (cmd_op == 2'd0) ? 1 : span_of(bus.scale);

   always_comb begin
      state_d     = state_q;
      clr_row_d   = clr_row_q;
      clr_data_d  = clr_data_q;
      cmd_ready_c = 1'b0;
      err_d       = 1'b0;
      row_we      = 1'b0;
      row_idx     = '0;
      row_mask    = '0;
      row_tile    = '0;
`ifdef TILE_READBACK_EN
      rd_valid_d  = 1'b0;
      rd_data_d   = '0;
`endif
      case (state_q)
         IDLE: begin
            cmd_ready_c = 1'b1;
            if (bus.cmd_valid) begin
               case (cmd_op)
                  2'd0, 2'd1: begin
                     if (cmd_oob) begin
                        err_d = 1'b1;
                     end else begin
                        row_we   = 1'b1;
                        row_idx  = cmd_y[RW-1:0];
                        row_tile = cmd_data;
                        // Span writes stop at the row end rather than wrapping.
                        for (int c = 0; c < COLS; c++)
                           row_mask[c] = (c >= int'(cmd_x)) && (c < int'(cmd_x) + cmd_span);
                     end
                  end
                  2'd2: begin
                     state_d    = CLEAR;
                     clr_row_d  = '0;
                     clr_data_d = cmd_data;
                  end
                  default: begin
`ifdef TILE_READBACK_EN
                     rd_valid_d = 1'b1;
                     err_d      = cmd_oob;
                     if (!cmd_oob)
                        for (int c = 0; c < COLS; c++)
                           if (c == int'(cmd_x))
                              rd_data_d = map_q[cmd_y[RW-1:0]][ROW_BITS-1-c*TILE_BITS -: TILE_BITS];
`endif
                  end
               endcase
            end
         end
         CLEAR: begin
            row_we   = 1'b1;
            row_idx  = clr_row_q;
            row_mask = '1;
            row_tile = clr_data_q;
            if (clr_row_q == RW'(ROWS-1))
               state_d = IDLE;
            else
               clr_row_d = clr_row_q + RW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         clr_row_q  <= '0;
         clr_data_q <= '0;
         err_q      <= 1'b0;
`ifdef TILE_READBACK_EN
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         clr_row_q  <= clr_row_d;
         clr_data_q <= clr_data_d;
         err_q      <= err_d;
`ifdef TILE_READBACK_EN
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
`endif
      end
   end

   // The map survives reset so a cleared or partially cleared image is kept.
   always_ff @(posedge clk50) begin
      if (row_we)
         for (int c = 0; c < COLS; c++)
            if (row_mask[c])
               map_q[row_idx][ROW_BITS-1-c*TILE_BITS -: TILE_BITS] <= row_tile;
   end

   // Stage 1: row lookup. The map read sees pre-write contents at this edge.
   assign px_div   = 9'(TILE_PX * span_of(bus.scale));
   assign tile_row = bus.line_num / px_div;

   always_comb begin
      line_exp = '0;
      for (int c = 0; c < COLS; c++)
         line_exp[LINE_W-1-PAD_BITS-c*CHUNK -: CHUNK] =
            {TILE_PX{s1_row_q[ROW_BITS-1-c*TILE_BITS -: TILE_BITS]}};
   end

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q   <= 1'b0;
         s1_row_q     <= '0;
         line_valid_q <= 1'b0;
         line_data_q  <= '0;
      end else begin
         s1_valid_q   <= bus.line_req;
         line_valid_q <= s1_valid_q;
         if (bus.line_req)
            s1_row_q <= (int'(tile_row) >= ROWS) ? '0 : map_q[tile_row[RW-1:0]];
         if (s1_valid_q)
            line_data_q <= line_exp;
      end
   end

   assign bus.cmd_ready  = cmd_ready_c;
   assign bus.err_oob    = err_q;
   assign bus.line_valid = line_valid_q;
   assign bus.line_data  = line_data_q;
`ifdef TILE_READBACK_EN
   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_data    = rd_data_q;
`endif
endmodule

// File: tb/tb_tile_map_renderer.sv
module tb_tile_map_renderer;
   localparam int COLS = 56, ROWS = 32, TB = 6, PX = 15, PAD = 24;
   localparam int LW = COLS*TB*PX + 2*PAD;

   logic clk50 = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk50 = ~clk50;

   tile_map_renderer_if #(.TILE_BITS(TB), .LINE_W(LW)) bus();

   tile_map_renderer #(.COLS(COLS), .ROWS(ROWS), .TILE_BITS(TB), .TILE_PX(PX),
                       .PAD_BITS(PAD), .LINE_W(LW)) dut (
      .clk50(clk50), .reset_n(reset_n), .bus(bus));

   typedef struct {
      logic [LW-1:0] data;
      int            due;
      int            ln;
   } exp_t;

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc = 0;
   exp_t          sb[$];
   exp_t          cur;
   logic [TB-1:0] model [ROWS][COLS];
   logic [LW-1:0] lit;

   always @(posedge clk50) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int span_of(input logic [1:0] s);
      if (s == 2'd1) return 2;
      if (s == 2'd3) return 4;
      return 1;
   endfunction

   function automatic logic [LW-1:0] exp_line(input int ln, input int s);
      logic [LW-1:0] r;
      int tr;
      r  = '0;
      tr = ln / (PX*s);
      if (tr < ROWS)
         for (int c = 0; c < COLS; c++)
            for (int k = 0; k < PX; k++)
               r[LW-1-PAD-(c*PX+k)*TB -: TB] = model[tr][c];
      return r;
   endfunction

   function automatic int first_diff(input logic [LW-1:0] a, input logic [LW-1:0] b);
      for (int i = LW-1; i >= 0; i--)
         if (a[i] !== b[i]) return i;
      return -1;
   endfunction

   task automatic model_apply(input int x, input int y, input int op, input logic [TB-1:0] d,
                              input logic [1:0] sc);
      int s;
      s = (op == 0) ? 1 : span_of(sc);
      if (op == 2) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) model[r][c] = d;
      end else if (op < 2 && x < COLS && y < ROWS) begin
         for (int i = 0; i < s; i++)
            if (x + i < COLS) model[y][x+i] = d;
      end
   endtask

   task automatic send_cmd(input int x, input int y, input int op, input logic [TB-1:0] d,
                           input logic [1:0] sc, input logic exp_err);
      int w;
      w = 0;
      bus.cmd       = {8'(x), 8'(y), 2'(op), d};
      bus.scale     = sc;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && w < 100) begin
         tick();
         w++;
      end
      chk("cmd_ready_wait", 32'(w < 100), 32'd1);
      tick();
      bus.cmd_valid = 1'b0;
      model_apply(x, y, op, d, sc);
      chk("err_oob", 32'(bus.err_oob), 32'(exp_err));
   endtask

   task automatic req_line(input int ln, input logic [1:0] sc);
      exp_t e;
      e.data = exp_line(ln, span_of(sc));
      e.due  = cyc + 2;
      e.ln   = ln;
      sb.push_back(e);
      bus.line_req = 1'b1;
      bus.line_num = 9'(ln);
      bus.scale    = sc;
      tick();
      bus.line_req = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) tick();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk50) begin
      if (reset_n && bus.line_valid) begin
         chk("line_valid_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("line_latency", 32'(cyc), 32'(cur.due));
            n_vec++;
            assert (bus.line_data === cur.data) else begin
               n_err++;
               $error("FAIL line_data line %0d: first differing bit %0d, observed ones %0d expected ones %0d",
                      cur.ln, first_diff(bus.line_data, cur.data),
                      $countones(bus.line_data), $countones(cur.data));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      bus.cmd = '0; bus.cmd_valid = 1'b0; bus.scale = 2'd0;
      bus.line_req = 1'b0; bus.line_num = '0;
      repeat (3) tick();
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_err_oob", 32'(bus.err_oob), 32'd0);
      chk("rst_line_valid", 32'(bus.line_valid), 32'd0);
      chk("rst_line_data_zero", 32'(bus.line_data == '0), 32'd1);
      reset_n = 1'b1;
      tick();

      // Clear: cmd_ready low for exactly ROWS cycles.
      send_cmd(0, 0, 2, 6'h00, 2'd0, 1'b0);
      w = 0;
      while (!bus.cmd_ready && w < 100) begin
         w++;
         tick();
      end
      chk("clear_busy_cycles", 32'(w), 32'd32);
      req_line(0, 2'd0);
      drain();

      // Single tile, line 14 is the last line of tile row 0.
      send_cmd(0, 0, 0, 6'h3F, 2'd0, 1'b0);
      req_line(14, 2'd0);
      tick();
      tick();
      chk("line_valid_one_pulse", 32'(bus.line_valid), 32'd0);
      lit = '0;
      lit[5063:4974] = '1;
      n_vec++;
      assert (bus.line_data === lit) else begin
         n_err++;
         $error("FAIL line14_literal_hold: first differing bit %0d, observed ones %0d expected ones 90",
                first_diff(bus.line_data, lit), $countones(bus.line_data));
      end
      req_line(15, 2'd0);
      drain();

      // Span write at the row end, scale x4: truncated, no wrap, no error.
      send_cmd(54, 1, 1, 6'h15, 2'd3, 1'b0);
      tick();
      chk("err_oob_quiet", 32'(bus.err_oob), 32'd0);
      req_line(60, 2'd3);
      req_line(120, 2'd3);
      req_line(30, 2'd0);
      drain();

      // Out-of-range commands are accepted but write nothing.
      send_cmd(56, 0, 0, 6'h3F, 2'd0, 1'b1);
      tick();
      chk("err_oob_single_pulse", 32'(bus.err_oob), 32'd0);
      send_cmd(0, 32, 0, 6'h2B, 2'd0, 1'b1);
      send_cmd(56, 5, 1, 6'h2B, 2'd3, 1'b1);
      req_line(0, 2'd0);
      drain();

      // Varied content, then back-to-back requests.
      send_cmd(5, 1, 0, 6'h2A, 2'd0, 1'b0);
      send_cmd(55, 31, 0, 6'h01, 2'd0, 1'b0);
      send_cmd(10, 2, 0, 6'h11, 2'd0, 1'b0);
      send_cmd(0, 31, 1, 6'h3C, 2'd1, 1'b0);
      req_line(0, 2'd0);
      req_line(15, 2'd0);
      req_line(30, 2'd0);
      req_line(479, 2'd0);
      drain();

      // Scale variants and out-of-range tile rows.
      req_line(59, 2'd1);
      req_line(15, 2'd2);
      req_line(480, 2'd0);
      req_line(511, 2'd1);
      req_line(511, 2'd3);
      req_line(479, 2'd3);
      drain();

      // Read and write of the same row in one cycle: read sees old data.
      chk("ready_before_overlap", 32'(bus.cmd_ready), 32'd1);
      begin
         exp_t e;
         e.data = exp_line(45, 1);
         e.due  = cyc + 2;
         e.ln   = 45;
         sb.push_back(e);
      end
      bus.cmd = {8'd1, 8'd3, 2'd0, 6'h3C}; bus.cmd_valid = 1'b1; bus.scale = 2'd0;
      bus.line_req = 1'b1; bus.line_num = 9'd45;
      tick();
      bus.cmd_valid = 1'b0; bus.line_req = 1'b0;
      model_apply(1, 3, 0, 6'h3C, 2'd0);
      req_line(45, 2'd0);
      drain();

`ifdef TILE_READBACK_EN
      send_cmd(3, 7, 0, 6'h2A, 2'd0, 1'b0);
      send_cmd(3, 7, 3, 6'h00, 2'd0, 1'b0);
      chk("rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("rd_data", 32'(bus.rd_data), 32'h2A);
      tick();
      chk("rd_valid_pulse", 32'(bus.rd_valid), 32'd0);
      send_cmd(60, 7, 3, 6'h00, 2'd0, 1'b1);
      chk("rd_valid_oob", 32'(bus.rd_valid), 32'd1);
      chk("rd_data_oob", 32'(bus.rd_data), 32'd0);
`else
      send_cmd(3, 7, 3, 6'h00, 2'd0, 1'b0);
      tick();
      chk("nop_no_err", 32'(bus.err_oob), 32'd0);
`endif

      // Reset during a clear keeps the partially cleared map.
      chk("ready_before_clear2", 32'(bus.cmd_ready), 32'd1);
      bus.cmd = {8'd0, 8'd0, 2'd2, 6'h0A}; bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      repeat (4) tick();
      #2 reset_n = 1'b0;
      #1;
      chk("midclear_rst_ready", 32'(bus.cmd_ready), 32'd1);
      chk("midclear_rst_line_data", 32'(bus.line_data == '0), 32'd1);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < COLS; c++) model[r][c] = 6'h0A;
      @(posedge clk50);
      #1 reset_n = 1'b1;
      tick();
      chk("after_rst_ready", 32'(bus.cmd_ready), 32'd1);
      req_line(45, 2'd0);
      req_line(60, 2'd0);
      req_line(15, 2'd0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
